// File: rtl/pool_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pool_sequencer
// Description : Address/control sequencer for 2x2 max/avg pooling of a
//               feature map streamed element-by-element from a systolic
//               array. Drives regfile read/write addresses, write strobes,
//               the pooling input mux and the completed-window index.
//               Optional macro POOL_PERF_EN adds a 16-bit RUN-cycle counter
//               output perf_cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module pool_sequencer #(
  parameter int IMG_W   = 8,
  parameter int IMG_H   = 8,
  parameter int ADDR_W  = 3,
  parameter int OADDR_W = 4
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               start,
  input  logic               in_valid,
  output logic               mux_en,
  output logic               wr_ctrl1,
  output logic               wr_ctrl2,
  output logic [ADDR_W-1:0]  current_adrs1,
  output logic [ADDR_W-1:0]  current_adrs2,
  output logic [ADDR_W-1:0]  current_adrs_out,
  output logic               out_valid,
  output logic [OADDR_W-1:0] out_idx,
  output logic               busy,
  output logic               pool_done
`ifdef POOL_PERF_EN
  ,
  output logic [15:0]        perf_cycles
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          run;
  logic          take;
  logic          col_last;
  logic          row_last;

  assign run      = (state == ST_RUN);
  assign take     = run && in_valid;
  assign col_last = (col == CW'(IMG_W - 1));
  assign row_last = (row == RW'(IMG_H - 1));

  // FSM and element counters; counters wrap back to 0 after the last element
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= ST_IDLE;
      col   <= '0;
      row   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_RUN;
            col   <= '0;
            row   <= '0;
          end
        end
        ST_RUN: begin
          if (in_valid) begin
            if (col_last) begin
              col <= '0;
              if (row_last) begin
                row   <= '0;
                state <= ST_DONE;
              end else begin
                row <= row + 1'b1;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Read and write share one regfile slot per column pair of the window
  assign current_adrs1    = ADDR_W'(col >> 1);
  assign current_adrs2    = ADDR_W'(col >> 1);
  assign current_adrs_out = ADDR_W'(col >> 1);

  // Zero-latency window decode from the parity of (row, col)
  always_comb begin
    mux_en    = 1'b0;
    wr_ctrl1  = 1'b0;
    wr_ctrl2  = 1'b0;
    out_valid = 1'b0;
    out_idx   = '0;
    if (run) begin
      // first element of a window passes raw; all others combine
      mux_en = row[0] | col[0];
      if (take) begin
        if (!row[0] && !col[0]) begin
          wr_ctrl1 = 1'b1;
        end else if (row[0] && col[0]) begin
          out_valid = 1'b1;
          out_idx   = OADDR_W'((32'(row >> 1) * (IMG_W / 2)) + 32'(col >> 1));
        end else begin
          wr_ctrl2 = 1'b1;
        end
      end
    end
  end

  assign busy      = run;
  assign pool_done = (state == ST_DONE);

`ifdef POOL_PERF_EN
  // RUN-cycle counter: cleared on accepted start, saturates, holds afterwards
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      perf_cycles <= 16'd0;
    end else if (state == ST_IDLE && start) begin
      perf_cycles <= 16'd0;
    end else if (run && perf_cycles != 16'hFFFF) begin
      perf_cycles <= perf_cycles + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pool_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pool_sequencer
// Description : Directed bench for pool_sequencer (4x4 map) with a reference
//               decode model, per-cycle expected-vector queue and an expected
//               window-index queue. Define POOL_PERF_EN to also check
//               perf_cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pool_sequencer;

  localparam int IMG_W   = 4;
  localparam int IMG_H   = 4;
  localparam int ADDR_W  = 3;
  localparam int OADDR_W = 4;

  logic               clk = 1'b0;
  logic               nrst = 1'b0;
  logic               start = 1'b0;
  logic               in_valid = 1'b0;
  logic               mux_en;
  logic               wr_ctrl1;
  logic               wr_ctrl2;
  logic [ADDR_W-1:0]  current_adrs1;
  logic [ADDR_W-1:0]  current_adrs2;
  logic [ADDR_W-1:0]  current_adrs_out;
  logic               out_valid;
  logic [OADDR_W-1:0] out_idx;
  logic               busy;
  logic               pool_done;
`ifdef POOL_PERF_EN
  logic [15:0]        perf_cycles;
`endif

  pool_sequencer #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .OADDR_W(OADDR_W)
  ) dut (
    .clk(clk), .nrst(nrst), .start(start), .in_valid(in_valid),
    .mux_en(mux_en), .wr_ctrl1(wr_ctrl1), .wr_ctrl2(wr_ctrl2),
    .current_adrs1(current_adrs1), .current_adrs2(current_adrs2),
    .current_adrs_out(current_adrs_out), .out_valid(out_valid),
    .out_idx(out_idx), .busy(busy), .pool_done(pool_done)
`ifdef POOL_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  // free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  logic [31:0] exp_q[$];
  int          win_q[$];

  // reference model: 0 = idle, 1 = run, 2 = done
  int m_st   = 0;
  int m_r    = 0;
  int m_c    = 0;
  int m_perf = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack(input logic mx, input logic w1, input logic w2,
                                       input logic [2:0] a1, input logic [2:0] a2,
                                       input logic [2:0] ao, input logic ov,
                                       input logic [3:0] ix, input logic dn,
                                       input logic bs);
    logic [31:0] v;
    v = '0;
    v[18:0] = {mx, w1, w2, a1, a2, ao, ov, ix, dn, bs};
    return v;
  endfunction

  function automatic logic [31:0] observe();
    return pack(mux_en, wr_ctrl1, wr_ctrl2, current_adrs1, current_adrs2,
                current_adrs_out, out_valid, out_idx, pool_done, busy);
  endfunction

  // expected outputs for the current model state with in_valid = v
  function automatic logic [31:0] expv(input logic v);
    logic       run, rodd, codd, ov;
    logic [2:0] a;
    logic [3:0] ix;
    run  = (m_st == 1);
    rodd = (m_r % 2) == 1;
    codd = (m_c % 2) == 1;
    a    = 3'(m_c / 2);
    ov   = run && v && rodd && codd;
    ix   = ov ? 4'((m_r / 2) * (IMG_W / 2) + m_c / 2) : 4'd0;
    return pack(run && (rodd || codd), run && v && !rodd && !codd,
                run && v && (rodd != codd), a, a, a, ov, ix, m_st == 2, run);
  endfunction

  // one clock cycle: drive, compare at the falling edge, then advance model
  task automatic step(input logic s, input logic v);
    @(posedge clk);
    #1;
    start    = s;
    in_valid = v;
    exp_q.push_back(expv(v));
    @(negedge clk);
    chk("cycle", observe(), exp_q.pop_front());
`ifdef POOL_PERF_EN
    chk("perf", 32'(perf_cycles), 32'(m_perf));
`endif
    if (out_valid) begin
      if (win_q.size() == 0) chk("win_extra", 32'(out_idx), 32'hFFFF_FFFF);
      else chk("win_idx", 32'(out_idx), 32'(win_q.pop_front()));
    end
    if (pool_done) chk("win_left", 32'(win_q.size()), 32'd0);
    case (m_st)
      0: if (s) begin
        m_st = 1; m_r = 0; m_c = 0; m_perf = 0;
        for (int k = 0; k < (IMG_W / 2) * (IMG_H / 2); k++) win_q.push_back(k);
      end
      1: begin
        if (m_perf < 65535) m_perf++;
        if (v) begin
          if (m_c == IMG_W - 1) begin
            m_c = 0;
            if (m_r == IMG_H - 1) begin m_r = 0; m_st = 2; end
            else m_r++;
          end else m_c++;
        end
      end
      default: m_st = 0;
    endcase
  endtask

  // asynchronous reset in the middle of a cycle
  task automatic async_reset();
    @(posedge clk);
    #2;
    nrst = 1'b0;
    #1;
    m_st = 0; m_r = 0; m_c = 0; m_perf = 0;
    exp_q.delete();
    win_q.delete();
    chk("rst_async", observe(), expv(in_valid));
`ifdef POOL_PERF_EN
    chk("rst_perf", 32'(perf_cycles), 32'd0);
`endif
    start    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    nrst = 1'b1;
  endtask

  initial begin
    // power-on reset state
    #2;
    chk("reset", observe(), 32'd0);
    @(negedge clk);
    #1;
    nrst = 1'b1;

    // in_valid while idle is ignored
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);

    // frame 1: back-to-back elements
    step(1'b1, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 1'b1);
      chk("ov_at", 32'(out_valid), 32'(i == 6 || i == 8 || i == 14 || i == 16));
      if (i == 3) chk("e02", {28'd0, wr_ctrl1, current_adrs_out}, {28'd0, 1'b1, 3'd1});
      if (i == 8)
        chk("e13", {27'd0, out_valid, current_adrs1, wr_ctrl1, wr_ctrl2},
            {27'd0, 1'b1, 3'd1, 1'b0, 1'b0});
    end
    step(1'b0, 1'b0);
    chk("done_pulse", 32'(pool_done), 32'd1);
    step(1'b0, 1'b0);

    // frame 2: in_valid every other cycle, stray start mid-run and in DONE
    step(1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1);
      step((i == 7 || i == 15) ? 1'b1 : 1'b0, 1'b0);
    end
    step(1'b0, 1'b0);
    chk("no_restart", 32'(busy), 32'd0);
    step(1'b0, 1'b1);

    // frame 3: 16 elements with 4 idle cycles
    step(1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1);
      if (i % 4 == 1) step(1'b0, 1'b0);
    end
    step(1'b0, 1'b0);
`ifdef POOL_PERF_EN
    chk("perf20", 32'(perf_cycles), 32'd20);
`endif
    step(1'b0, 1'b0);
`ifdef POOL_PERF_EN
    chk("perf_hold", 32'(perf_cycles), 32'd20);
`endif

    // frame 4: reset after 9 elements, then a full frame
    step(1'b1, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1);
    in_valid = 1'b1;
    async_reset();
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("done_after_rst", 32'(pool_done), 32'd1);
    step(1'b0, 1'b0);
    chk("win_q_empty", 32'(win_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
